traffic_conflict_monitor: RTL and testbench

Safety stage directly downstream of the four-approach traffic light sequencer. Registers the sequencer's lamp codes, checks every cycle for illegal codes, conflicting right-of-way and illegal lamp transitions, and forwards the codes to the lamp drivers. On any violation it latches a fault and overrides all approaches with flashing red until an operator clears it.

---
 rtl/traffic_conflict_monitor.sv | 184 ++++++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor.sv
// rtl/traffic_conflict_monitor.sv - lamp-code safety checker with latched fault and flashing-red override
module traffic_conflict_monitor #(
    parameter int STARTUP_CYC = 4,
    parameter int YEL_MIN     = 1,
    parameter int FLASH_HALF  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] north_in,
    input  logic [2:0] east_in,
    input  logic [2:0] south_in,
    input  logic [2:0] west_in,
    input  logic       clear,
    output logic [2:0] north_out,
    output logic [2:0] east_out,
    output logic [2:0] south_out,
    output logic [2:0] west_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir
);
    localparam logic [2:0] RED  = 3'b001;
    localparam logic [2:0] GRN  = 3'b010;
    localparam logic [2:0] YEL  = 3'b100;
    localparam logic [2:0] DARK = 3'b000;
    localparam int SW = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
    localparam int YW = $clog2(YEL_MIN + 1);
    localparam int FW = $clog2(2 * FLASH_HALF);

    typedef enum logic [1:0] {
        ST_STARTUP,
        ST_MONITOR,
        ST_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       scnt_q, scnt_d;
    logic [FW-1:0]       fcnt_q, fcnt_d;
    logic [3:0][2:0]     s1_q, s1_d;
    logic [3:0][2:0]     prev_q, prev_d;
    logic [3:0][2:0]     out_q, out_d;
    logic [3:0][YW-1:0]  ycnt_q, ycnt_d;
    logic                fault_q, fault_d;
    logic [2:0]          code_q, code_d;
    logic [1:0]          dir_q, dir_d;

    logic [3:0]          bad, nonred, skip_y, y2g, short_y;
    logic [2:0]          det_code;
    logic [1:0]          det_dir;

    function automatic logic [1:0] first_set(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Index 0 is north, matching the fault_dir encoding.
    always_comb begin
        s1_d   = {west_in, south_in, east_in, north_in};
        prev_d = s1_q;
        for (int i = 0; i < 4; i++) begin
            if (s1_q[i] == YEL)
                ycnt_d[i] = (ycnt_q[i] == YW'(YEL_MIN)) ? ycnt_q[i] : ycnt_q[i] + YW'(1);
            else
                ycnt_d[i] = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bad[i]     = !(s1_q[i] == RED || s1_q[i] == GRN || s1_q[i] == YEL);
            nonred[i]  = (s1_q[i] != RED);
            skip_y[i]  = (prev_q[i] == GRN) && (s1_q[i] == RED);
            y2g[i]     = (prev_q[i] == YEL) && (s1_q[i] == GRN);
            short_y[i] = (prev_q[i] == YEL) && (s1_q[i] == RED) && (ycnt_q[i] < YW'(YEL_MIN));
        end
        det_code = 3'd0;
        det_dir  = 2'd0;
        // Evaluated from highest to lowest code so the lowest code overrides.
        if (|short_y) begin
            det_code = 3'd5;
            det_dir  = first_set(short_y);
        end
        if (|y2g) begin
            det_code = 3'd4;
            det_dir  = first_set(y2g);
        end
        if (|skip_y) begin
            det_code = 3'd3;
            det_dir  = first_set(skip_y);
        end
        if ($countones(nonred) > 1) begin
            det_code = 3'd2;
            det_dir  = first_set(nonred);
        end
        if (|bad) begin
            det_code = 3'd1;
            det_dir  = first_set(bad);
        end
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        fcnt_d  = fcnt_q;
        out_d   = {4{RED}};
        fault_d = fault_q;
        code_d  = code_q;
        dir_d   = dir_q;
        case (state_q)
            ST_STARTUP: begin
                if (scnt_q == SW'(STARTUP_CYC - 1)) begin
                    state_d = ST_MONITOR;
                    scnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            ST_MONITOR: begin
                if (det_code != 3'd0) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = det_code;
                    dir_d   = det_dir;
                    fcnt_d  = '0;
                end else begin
                    out_d = s1_q;
                end
            end
            ST_FAULT: begin
                if (clear) begin
                    state_d = ST_STARTUP;
                    scnt_d  = '0;
                    fcnt_d  = '0;
                    fault_d = 1'b0;
                    code_d  = 3'd0;
                    dir_d   = 2'd0;
                end else begin
                    fcnt_d = (fcnt_q == FW'(2 * FLASH_HALF - 1)) ? '0 : fcnt_q + FW'(1);
                    out_d  = (fcnt_d < FW'(FLASH_HALF)) ? {4{RED}} : {4{DARK}};
                end
            end
            default: state_d = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STARTUP;
            scnt_q  <= '0;
            fcnt_q  <= '0;
            s1_q    <= {4{RED}};
            prev_q  <= {4{RED}};
            out_q   <= {4{RED}};
            ycnt_q  <= '0;
            fault_q <= 1'b0;
            code_q  <= 3'd0;
            dir_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            fcnt_q  <= fcnt_d;
            s1_q    <= s1_d;
            prev_q  <= prev_d;
            out_q   <= out_d;
            ycnt_q  <= ycnt_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            dir_q   <= dir_d;
        end
    end

    assign north_out  = out_q[0];
    assign east_out   = out_q[1];
    assign south_out  = out_q[2];
    assign west_out   = out_q[3];
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_dir  = dir_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb/tb_traffic_conflict_monitor.sv - scoreboard bench for traffic_conflict_monitor
module tb_traffic_conflict_monitor;
    localparam int STARTUP_CYC = 4;
    localparam logic [2:0] R = 3'b001, G = 3'b010, Y = 3'b100, D = 3'b000;
    localparam logic [11:0] AR = 12'h249;
    localparam logic [11:0] AD = 12'h000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic [2:0] n_in = R, e_in = R, s_in = R, w_in = R;
    logic [2:0] n_out, e_out, s_out, w_out;
    logic f_out;
    logic [2:0] c_out;
    logic [1:0] d_out;
    logic [2:0] n2_in = R, e2_in = R, s2_in = R, w2_in = R;
    logic [2:0] n2_out, e2_out, s2_out, w2_out;
    logic f2_out;
    logic [2:0] c2_out;
    logic [1:0] d2_out;

    always #5 clk = ~clk;

    traffic_conflict_monitor #(.STARTUP_CYC(STARTUP_CYC), .YEL_MIN(1), .FLASH_HALF(4)) dut (
        .clk(clk), .rst(rst),
        .north_in(n_in), .east_in(e_in), .south_in(s_in), .west_in(w_in),
        .clear(clear),
        .north_out(n_out), .east_out(e_out), .south_out(s_out), .west_out(w_out),
        .fault(f_out), .fault_code(c_out), .fault_dir(d_out)
    );

    traffic_conflict_monitor #(.STARTUP_CYC(STARTUP_CYC), .YEL_MIN(2), .FLASH_HALF(4)) dut2 (
        .clk(clk), .rst(rst),
        .north_in(n2_in), .east_in(e2_in), .south_in(s2_in), .west_in(w2_in),
        .clear(clear),
        .north_out(n2_out), .east_out(e2_out), .south_out(s2_out), .west_out(w2_out),
        .fault(f2_out), .fault_code(c2_out), .fault_dir(d2_out)
    );

    typedef struct {
        bit          sel;
        logic [11:0] outs;
        logic        f;
        logic [2:0]  code;
        logic [1:0]  dir;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    event async_ev;

    function automatic logic [11:0] pk(input logic [2:0] n, e, s, w);
        return {w, s, e, n};
    endfunction

    task automatic push(input string nm, input bit sel, input logic [11:0] out_e,
                        input logic f_e, input logic [2:0] c_e, input logic [1:0] d_e);
        exp_t x;
        x.sel = sel; x.outs = out_e; x.f = f_e; x.code = c_e; x.dir = d_e; x.nm = nm;
        sb.push_back(x);
    endtask

    task automatic check_one();
        exp_t x;
        logic [11:0] got;
        logic gf;
        logic [2:0] gc;
        logic [1:0] gd;
        if (sb.size() == 0) return;
        x = sb.pop_front();
        if (x.sel) begin
            got = {w2_out, s2_out, e2_out, n2_out}; gf = f2_out; gc = c2_out; gd = d2_out;
        end else begin
            got = {w_out, s_out, e_out, n_out}; gf = f_out; gc = c_out; gd = d_out;
        end
        vectors++;
        if (got !== x.outs || gf !== x.f || gc !== x.code || gd !== x.dir) begin
            miscompares++;
            $display("FAIL %s: got out=%h fault=%b code=%0d dir=%0d, required out=%h fault=%b code=%0d dir=%0d",
                     x.nm, got, gf, gc, gd, x.outs, x.f, x.code, x.dir);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check_one();
    end

    always @(async_ev) begin
        #1;
        check_one();
    end

    // Called just after a negedge; the expectation is for the state after the next posedge.
    task automatic step(input string nm, input bit sel, input logic [11:0] in_v, input bit clr,
                        input logic [11:0] out_e, input logic f_e, input logic [2:0] c_e,
                        input logic [1:0] d_e);
        if (sel) {w2_in, s2_in, e2_in, n2_in} = in_v;
        else     {w_in, s_in, e_in, n_in} = in_v;
        clear = clr;
        push(nm, sel, out_e, f_e, c_e, d_e);
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic recover(input string nm);
        step({nm, "_clr"}, 0, AR, 1, AR, 0, 0, 0);
        for (int i = 0; i < STARTUP_CYC; i++) step({nm, "_startup"}, 0, AR, 0, AR, 0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        push("reset_state", 0, AR, 0, 0, 0);
        -> async_ev;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < STARTUP_CYC; i++) step("startup_red", 0, pk(G, R, R, R), 0, AR, 0, 0, 0);
        step("startup_first_out", 0, pk(G, R, R, R), 0, pk(G, R, R, R), 0, 0, 0);

        step("rot1", 0, pk(Y, R, R, R), 0, pk(G, R, R, R), 0, 0, 0);
        step("rot2", 0, pk(R, G, R, R), 0, pk(Y, R, R, R), 0, 0, 0);
        step("rot3", 0, pk(R, Y, R, R), 0, pk(R, G, R, R), 0, 0, 0);
        step("rot4", 0, pk(R, R, G, R), 0, pk(R, Y, R, R), 0, 0, 0);
        step("rot5", 0, pk(R, R, Y, R), 0, pk(R, R, G, R), 0, 0, 0);
        step("rot6", 0, pk(R, R, R, G), 0, pk(R, R, Y, R), 0, 0, 0);
        step("rot7_clear_ignored", 0, pk(R, R, R, Y), 1, pk(R, R, R, G), 0, 0, 0);
        step("rot8", 0, AR, 0, pk(R, R, R, Y), 0, 0, 0);
        step("rot9", 0, AR, 0, AR, 0, 0, 0);

        step("conf_in", 0, pk(G, G, R, R), 0, AR, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("conf_flash_red", 0, AR, 0, AR, 1, 2, 0);
        for (int i = 0; i < 4; i++) step("conf_flash_dark", 0, AR, 0, AD, 1, 2, 0);
        step("conf_flash_wrap", 0, AR, 0, AR, 1, 2, 0);
        step("conf_clear", 0, pk(G, R, R, R), 1, AR, 0, 0, 0);
        for (int i = 0; i < STARTUP_CYC; i++) step("restart_red", 0, pk(G, R, R, R), 0, AR, 0, 0, 0);
        step("restart_out", 0, pk(Y, R, R, R), 0, pk(G, R, R, R), 0, 0, 0);
        step("restart_y", 0, AR, 0, pk(Y, R, R, R), 0, 0, 0);
        step("restart_r", 0, AR, 0, AR, 0, 0, 0);

        step("inv_in", 0, pk(G, R, G, 3'b011), 0, AR, 0, 0, 0);
        step("inv_fault", 0, AR, 0, AR, 1, 1, 3);
        recover("inv");

        step("skip_y_g", 0, pk(G, R, R, R), 0, AR, 0, 0, 0);
        step("skip_y_r", 0, AR, 0, pk(G, R, R, R), 0, 0, 0);
        step("skip_y_fault", 0, AR, 0, AR, 1, 3, 0);
        recover("skip_y");

        step("y2g_y", 0, pk(R, Y, R, R), 0, AR, 0, 0, 0);
        step("y2g_g", 0, pk(R, G, R, R), 0, pk(R, Y, R, R), 0, 0, 0);
        step("y2g_fault", 0, AR, 0, AR, 1, 4, 1);
        recover("y2g");

        step("ymin2_y1", 1, pk(R, R, Y, R), 0, AR, 0, 0, 0);
        step("ymin2_y2", 1, pk(R, R, Y, R), 0, pk(R, R, Y, R), 0, 0, 0);
        step("ymin2_r", 1, AR, 0, pk(R, R, Y, R), 0, 0, 0);
        step("ymin2_ok", 1, AR, 0, AR, 0, 0, 0);
        step("short_y_y", 1, pk(R, R, Y, R), 0, AR, 0, 0, 0);
        step("short_y_r", 1, AR, 0, pk(R, R, Y, R), 0, 0, 0);
        step("short_y_fault", 1, AR, 0, AR, 1, 5, 2);

        step("ew_conf_in", 0, pk(R, G, R, G), 0, AR, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("ew_conf_red", 0, AR, 0, AR, 1, 2, 1);
        step("ew_conf_dark", 0, AR, 0, AD, 1, 2, 1);
        rst = 1'b1;
        push("rst_mid_flash", 0, AR, 0, 0, 0);
        -> async_ev;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
